// File: rtl/iterative_arith_unit_if.sv
// Handshake and operand bus for iterative_arith_unit: request side drives start/mode/operands,
// the unit returns busy/done and the held result/overflow.
interface iterative_arith_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (
    output start, mode, input_a, input_b,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, mode, input_a, input_b,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/iterative_arith_unit.sv
// Multi-cycle shift-add multiply, digit-by-digit square root and (with ITER_DIV_EN defined)
// restoring divide, one iteration per clock, with a start/done handshake and held result.
module iterative_arith_unit #(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clock,
  input logic                  reset,
  iterative_arith_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMul  = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntSqrt = CntW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;
  typedef enum logic [1:0] {OpMul, OpSqrt, OpDiv, OpRsv} op_e;

  state_e state_q, state_d;
  op_e    op_q, op_d;

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] a_q, a_d;      // multiplicand / radicand / dividend-quotient shifter
  logic [WIDTH-1:0]   b_q, b_d;      // multiplier / divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;  // product / partial remainder
  logic [WIDTH-1:0]   root_q, root_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] rem_sh;
  logic [2*WIDTH-1:0] trial;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StCalc;
      StCalc:  if (cnt_q == '0) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = (state_q != StIdle);
  end

  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    root_d   = root_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    rem_sh   = '0;
    trial    = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d    = {{WIDTH{1'b0}}, bus.input_a};
          b_d    = bus.input_b;
          acc_d  = '0;
          root_d = '0;
          case (bus.mode)
            2'b00: begin op_d = OpMul;  cnt_d = CntMul;  end
            2'b01: begin op_d = OpSqrt; cnt_d = CntSqrt; end
`ifdef ITER_DIV_EN
            2'b10: begin op_d = OpDiv;  cnt_d = CntMul;  end
`endif
            default: begin op_d = OpRsv; cnt_d = '0; end
          endcase
        end
      end

      StCalc: begin
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        case (op_q)
          OpMul: begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d = a_q << 1;
            b_d = b_q >> 1;
          end
          OpSqrt: begin
            // Bring down the next radicand bit pair and try root*4+1.
            rem_sh = {acc_q[2*WIDTH-3:0], a_q[WIDTH-1 -: 2]};
            trial  = {{WIDTH{1'b0}}, root_q[WIDTH-3:0], 2'b01};
            if (rem_sh >= trial) begin
              acc_d  = rem_sh - trial;
              root_d = {root_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d  = rem_sh;
              root_d = {root_q[WIDTH-2:0], 1'b0};
            end
            a_d = a_q << 2;
          end
`ifdef ITER_DIV_EN
          OpDiv: begin
            // Quotient bits shift in at the bottom as dividend bits leave the top;
            // a zero divisor naturally yields an all-ones quotient.
            rem_sh = {acc_q[2*WIDTH-2:0], a_q[WIDTH-1]};
            a_d    = a_q << 1;
            if (rem_sh >= {{WIDTH{1'b0}}, b_q}) begin
              acc_d  = rem_sh - {{WIDTH{1'b0}}, b_q};
              a_d[0] = 1'b1;
            end else begin
              acc_d = rem_sh;
            end
          end
`endif
          default: ;
        endcase
      end

      StFin: begin
        done_d = 1'b1;
        case (op_q)
          OpMul: begin
            result_d = acc_q[WIDTH-1:0];
            ovf_d    = |acc_q[2*WIDTH-1:WIDTH];
          end
          OpSqrt: begin
            result_d = root_q;
            ovf_d    = 1'b0;
          end
`ifdef ITER_DIV_EN
          OpDiv: begin
            result_d = a_q[WIDTH-1:0];
            ovf_d    = (b_q == '0);
          end
`endif
          default: begin
            result_d = '0;
            ovf_d    = 1'b1;
          end
        endcase
      end

      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q     <= OpMul;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      root_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      root_q   <= root_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;

endmodule
